seg595_scan_n: RTL and testbench

Parametrised multiplexed 7-segment scanner driving a chain of 74HC595 shift registers: each scan slot serialises one frame (one-hot digit select plus that digit's 8-bit segment pattern) onto `ds`/`shcp`, then latches it with an `stcp` pulse. It sits between the display data path (BCD-to-segment encoding, score/timer logic) and the board's 595 pins. It generalises the fixed six-digit scanner with these additions:
- configurable digit count and scan period;
- per-digit blanking;
- a global enable;
- tear-free frame capture;
- a frame-done strobe;
- optional PWM brightness.

---
 rtl/seg595_scan_n.sv | 133 +++++++++++++
 tb/tb_seg595_scan_n.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg595_scan_n.sv
// seg595_scan_n: multiplexed 7-segment scanner feeding a 74HC595 chain.
// Each scan slot serialises {one-hot digit select, segment pattern} LSB-first
// on ds/shcp (4 clocks per bit) and then latches it with a single stcp pulse.
// Optional PWM brightness on oe is enabled by defining SEG595_PWM_EN.
module seg595_scan_n #(
   parameter int DIGITS  = 6,
   parameter int CNT_MAX = 49_999
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  en,
   input  logic [8*DIGITS-1:0]   seg_data,
   input  logic [DIGITS-1:0]     blank,
`ifdef SEG595_PWM_EN
   input  logic [3:0]            brightness,
`endif
   output logic                  ds,
   output logic                  shcp,
   output logic                  stcp,
   output logic                  oe,
   output logic                  frame_done
);

   localparam int W  = DIGITS + 8;
   localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int SW = $clog2(4 * W);
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX);
   localparam logic [SW-1:0] STEP_LAST = SW'(4 * W - 1);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t          state;
   logic [CW-1:0]   cnt_scan;
   logic [SW-1:0]   step;
   logic [DW-1:0]   digit;
   logic [W-1:0]    frame_reg;

   logic            tick;
   logic [DIGITS-1:0] sel_next;
   logic [7:0]      seg_next;
   logic [W-1:0]    frame_next;
   logic [SW-1:0]   step_next;
   logic [SW-3:0]   bit_next;
   logic            oe_next;

`ifdef SEG595_PWM_EN
   logic [3:0]      pwm_cnt;
`endif

   assign tick = (cnt_scan == CNT_LAST);

   // Build the frame for the current digit straight from the inputs so the
   // first bit can be presented in the cycle right after the tick.
   always_comb begin
      sel_next        = '0;
      sel_next[digit] = 1'b1;
      seg_next        = blank[digit] ? 8'hFF : seg_data[8*digit +: 8];
      frame_next      = {sel_next, seg_next};
      step_next       = step + 1'b1;
      bit_next        = step_next[SW-1:2];
   end

`ifdef SEG595_PWM_EN
   // Free-running PWM phase; oe is on while the phase is within the duty.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) pwm_cnt <= '0;
      else         pwm_cnt <= pwm_cnt + 1'b1;
   end

   assign oe_next = ~(en && (pwm_cnt <= brightness));
`else
   assign oe_next = ~en;
`endif

   // Slot counter, shift/latch sequencer and all registered pin outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         cnt_scan   <= '0;
         step       <= '0;
         digit      <= '0;
         frame_reg  <= '0;
         ds         <= 1'b0;
         shcp       <= 1'b0;
         stcp       <= 1'b0;
         oe         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt_scan <= tick ? '0 : cnt_scan + 1'b1;
         oe       <= oe_next;
         case (state)
            IDLE: begin
               stcp       <= 1'b0;
               frame_done <= 1'b0;
               shcp       <= 1'b0;
               ds         <= 1'b0;
               if (tick) begin
                  state     <= SHIFT;
                  step      <= '0;
                  frame_reg <= frame_next;
                  ds        <= frame_next[0];
               end
            end
            SHIFT: begin
               if (step == STEP_LAST) begin
                  state      <= LATCH;
                  stcp       <= 1'b1;
                  frame_done <= 1'b1;
                  shcp       <= 1'b0;
                  ds         <= 1'b0;
               end else begin
                  step <= step_next;
                  ds   <= frame_reg[bit_next];
                  shcp <= step_next[1];
               end
            end
            LATCH: begin
               state      <= IDLE;
               stcp       <= 1'b0;
               frame_done <= 1'b0;
               shcp       <= 1'b0;
               ds         <= 1'b0;
               digit      <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg595_scan_n.sv
// Self-checking bench for seg595_scan_n (DIGITS=6, CNT_MAX=99, W=14).
module tb_seg595_scan_n;

   localparam int DIGITS  = 6;
   localparam int CNT_MAX = 99;
   localparam int W       = 14;
   localparam int LAT_OFF = 4 * W + 1;

   logic                sys_clk = 1'b0;
   logic                sys_rst = 1'b1;
   logic                en = 1'b0;
   logic [8*DIGITS-1:0] seg_data = '0;
   logic [DIGITS-1:0]   blank = '0;
`ifdef SEG595_PWM_EN
   logic [3:0]          brightness = 4'd15;
`endif
   logic ds, shcp, stcp, oe, frame_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;

   logic [7:0] pattern [DIGITS];
   int next_digit;
   int last_exp;

   typedef struct {
      logic [W-1:0] word;
      int           nbits;
      int           stcp_cyc;
      int           first_rise;
      logic         fd;
   } obs_t;

   typedef struct {
      logic [W-1:0] word;
      int           stcp_cyc;
   } exp_t;

   obs_t obs_q[$];
   exp_t exp_q[$];

   logic [W-1:0] mon_word = '0;
   int           mon_bits = 0;
   int           mon_first = -1;
   logic         mon_prev = 1'b0;
   int           stray = 0;

   seg595_scan_n #(.DIGITS(DIGITS), .CNT_MAX(CNT_MAX)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .en        (en),
      .seg_data  (seg_data),
      .blank     (blank),
`ifdef SEG595_PWM_EN
      .brightness(brightness),
`endif
      .ds        (ds),
      .shcp      (shcp),
      .stcp      (stcp),
      .oe        (oe),
      .frame_done(frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Observe the 595 pins: collect bits on shcp rising edges, close a frame on stcp.
   always @(negedge sys_clk) begin
      if (frame_done !== stcp) stray++;
      if (sys_rst) begin
         mon_bits  = 0;
         mon_first = -1;
         mon_prev  = 1'b0;
      end else begin
         if (shcp && !mon_prev) begin
            mon_word = {ds, mon_word[W-1:1]};
            if (mon_bits == 0) mon_first = cyc;
            mon_bits++;
         end
         mon_prev = shcp;
         if (stcp) begin
            obs_q.push_back('{word: mon_word, nbits: mon_bits, stcp_cyc: cyc,
                              first_rise: mon_first, fd: frame_done});
            mon_bits  = 0;
            mon_first = -1;
         end
      end
   end

   function automatic logic [W-1:0] frame_of(int d);
      logic [DIGITS-1:0] sel;
      logic [7:0]        seg;
      sel = '0;
      sel[d] = 1'b1;
      seg = blank[d] ? 8'hFF : pattern[d];
      return {sel, seg};
   endfunction

   task automatic applyStimulus();
      for (int i = 0; i < DIGITS; i++) seg_data[8*i +: 8] = pattern[i];
   endtask

   task automatic push_expected(int stcp_at);
      exp_t e;
      e.word     = frame_of(next_digit);
      e.stcp_cyc = stcp_at;
      exp_q.push_back(e);
      last_exp   = stcp_at;
      next_digit = (next_digit + 1) % DIGITS;
   endtask

   task automatic wait_obs(output bit ok, output obs_t o);
      ok = 1'b0;
      o  = '{word: 'x, nbits: -1, stcp_cyc: -1, first_rise: -1, fd: 1'bx};
      for (int i = 0; i < 400; i++) begin
         if (obs_q.size() > 0) begin
            o  = obs_q.pop_front();
            ok = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
   endtask

   task automatic release_reset();
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      base = cyc;
   endtask

   task automatic test_reset();
      int   errs;
      bit   ok;
      obs_t o;
      exp_t e;
      en = 1'b0;
      applyStimulus();
      release_reset();
      next_digit = 0;
      push_expected(base + CNT_MAX + LAT_OFF);
      errs = 0;
      for (int i = 0; i <= CNT_MAX; i++) begin
         @(negedge sys_clk);
         if ({ds, shcp, stcp, oe, frame_done} !== 5'b00010) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("[TB] FAIL reset_idle: %0d cycles off reset values, required 0", errs);
      end
      @(negedge sys_clk);
      total++;
      if (ds !== pattern[0][0] || shcp !== 1'b0) begin
         bad++;
         $display("[TB] FAIL first_bit: ds=%b shcp=%b, required ds=%b shcp=0", ds, shcp, pattern[0][0]);
      end
      wait_obs(ok, o);
      e = exp_q.pop_front();
      total++;
      if (!ok || o.word !== e.word) begin
         bad++;
         $display("[TB] FAIL reset_frame_word: got %b, required %b", o.word, e.word);
      end
      total++;
      if (o.stcp_cyc - base !== CNT_MAX + LAT_OFF) begin
         bad++;
         $display("[TB] FAIL reset_stcp_cycle: got %0d, required %0d", o.stcp_cyc - base, CNT_MAX + LAT_OFF);
      end
      total++;
      if (o.nbits !== W) begin
         bad++;
         $display("[TB] FAIL reset_bit_count: got %0d, required %0d", o.nbits, W);
      end
      total++;
      if (o.first_rise - base !== CNT_MAX + 3) begin
         bad++;
         $display("[TB] FAIL first_shcp_rise: got %0d, required %0d", o.first_rise - base, CNT_MAX + 3);
      end
      total++;
      if (o.fd !== 1'b1) begin
         bad++;
         $display("[TB] FAIL frame_done_with_stcp: got %b, required 1", o.fd);
      end
      en = 1'b1;
   endtask

   task automatic test_rotation();
      bit   ok;
      obs_t o;
      exp_t e;
      for (int f = 1; f <= DIGITS; f++) begin
         push_expected(last_exp + CNT_MAX + 1);
         wait_obs(ok, o);
         e = exp_q.pop_front();
         total++;
         if (!ok || o.word !== e.word) begin
            bad++;
            $display("[TB] FAIL rotation_word[%0d]: got %b, required %b", f, o.word, e.word);
         end
         total++;
         if (o.stcp_cyc !== e.stcp_cyc) begin
            bad++;
            $display("[TB] FAIL rotation_period[%0d]: stcp at %0d, required %0d", f, o.stcp_cyc, e.stcp_cyc);
         end
      end
   endtask

   task automatic test_blank();
      bit   ok;
      obs_t o;
      exp_t e;
      blank = 6'b000100;
      for (int f = 0; f < 2; f++) begin
         push_expected(last_exp + CNT_MAX + 1);
         wait_obs(ok, o);
         e = exp_q.pop_front();
         total++;
         if (!ok || o.word !== e.word) begin
            bad++;
            $display("[TB] FAIL blank_word[%0d]: got %b, required %b", f, o.word, e.word);
         end
      end
   endtask

   task automatic test_tear_free();
      bit   ok;
      obs_t o;
      exp_t e;
      int   target;
      int   d;
      d = next_digit;
      push_expected(last_exp + CNT_MAX + 1);
      target = last_exp - LAT_OFF + 20;
      while (cyc < target) @(negedge sys_clk);
      pattern[d] = ~pattern[d];
      blank[d]   = 1'b1;
      applyStimulus();
      wait_obs(ok, o);
      e = exp_q.pop_front();
      total++;
      if (!ok || o.word !== e.word) begin
         bad++;
         $display("[TB] FAIL tear_free_word: got %b, required %b", o.word, e.word);
      end
      blank[d] = 1'b0;
   endtask

   task automatic test_enable();
      bit   ok;
      obs_t o;
      exp_t e;
      int   target;
      push_expected(last_exp + CNT_MAX + 1);
      target = last_exp - LAT_OFF + 10;
      while (cyc < target) @(negedge sys_clk);
      en = 1'b0;
      total++;
      if (oe !== 1'b0) begin
         bad++;
         $display("[TB] FAIL oe_latency: oe=%b same cycle as en drop, required 0", oe);
      end
      @(negedge sys_clk);
      total++;
      if (oe !== 1'b1) begin
         bad++;
         $display("[TB] FAIL oe_disable: oe=%b, required 1", oe);
      end
      en = 1'b1;
      @(negedge sys_clk);
      total++;
      if (oe !== 1'b0) begin
         bad++;
         $display("[TB] FAIL oe_enable: oe=%b, required 0", oe);
      end
      wait_obs(ok, o);
      e = exp_q.pop_front();
      total++;
      if (!ok || o.word !== e.word) begin
         bad++;
         $display("[TB] FAIL enable_frame_word: got %b, required %b", o.word, e.word);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit   ok;
      obs_t o;
      exp_t e;
      int   target;
      int   errs;
      target = last_exp + CNT_MAX + 1 - LAT_OFF + 20;
      while (cyc < target) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      total++;
      if ({ds, shcp, stcp, oe, frame_done} !== 5'b00010) begin
         bad++;
         $display("[TB] FAIL mid_reset_outputs: {ds,shcp,stcp,oe,fd}=%b, required 00010",
                  {ds, shcp, stcp, oe, frame_done});
      end
      errs = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (stcp !== 1'b0) errs++;
      end
      total++;
      if (errs != 0 || obs_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL mid_reset_no_stcp: %0d stcp cycles, %0d frames seen, required 0", errs, obs_q.size());
      end
      release_reset();
      next_digit = 0;
      push_expected(base + CNT_MAX + LAT_OFF);
      wait_obs(ok, o);
      e = exp_q.pop_front();
      total++;
      if (!ok || o.word !== e.word) begin
         bad++;
         $display("[TB] FAIL after_reset_word: got %b, required %b", o.word, e.word);
      end
      total++;
      if (o.stcp_cyc !== e.stcp_cyc) begin
         bad++;
         $display("[TB] FAIL after_reset_stcp_cycle: got %0d, required %0d", o.stcp_cyc, e.stcp_cyc);
      end
   endtask

`ifdef SEG595_PWM_EN
   task automatic test_pwm();
      int lows;
      brightness = 4'd3;
      repeat (2) @(negedge sys_clk);
      lows = 0;
      repeat (32) begin
         @(negedge sys_clk);
         if (oe === 1'b0) lows++;
      end
      total++;
      if (lows != 8) begin
         bad++;
         $display("[TB] FAIL pwm_duty_3: oe low %0d of 32, required 8", lows);
      end
      brightness = 4'd15;
      repeat (2) @(negedge sys_clk);
      lows = 0;
      repeat (16) begin
         @(negedge sys_clk);
         if (oe === 1'b0) lows++;
      end
      total++;
      if (lows != 16) begin
         bad++;
         $display("[TB] FAIL pwm_duty_15: oe low %0d of 16, required 16", lows);
      end
      en = 1'b0;
      repeat (2) @(negedge sys_clk);
      lows = 0;
      repeat (16) begin
         @(negedge sys_clk);
         if (oe === 1'b0) lows++;
      end
      total++;
      if (lows != 0) begin
         bad++;
         $display("[TB] FAIL pwm_disabled: oe low %0d of 16, required 0", lows);
      end
      en = 1'b1;
   endtask
`endif

   task automatic checkOutput();
      total++;
      if (stray != 0) begin
         bad++;
         $display("[TB] FAIL frame_done_vs_stcp: %0d cycles differ, required 0", stray);
      end
   endtask

   initial begin
      pattern[0] = 8'hC0;
      pattern[1] = 8'hF9;
      pattern[2] = 8'hA4;
      pattern[3] = 8'hB0;
      pattern[4] = 8'h99;
      pattern[5] = 8'h92;
      next_digit = 0;
      last_exp   = 0;
      test_reset();
      test_rotation();
      test_blank();
      test_tear_free();
      test_enable();
      test_reset_mid_frame();
`ifdef SEG595_PWM_EN
      test_pwm();
`endif
      checkOutput();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
